// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
package mdu_seq_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } mdu_state_e;

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Magnitude of an operand whose sign flag was already qualified by signedness.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Pipeline-facing request/result bundle of the multiply/divide unit.
interface mdu_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mdu_seq_csa32.sv
// 32-bit carry-select adder: low half ripples, high half precomputed for both carries.
module csa32 (
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        carry_in,
  output logic [31:0] dout,
  output logic        carry_out,
  output logic        overflow
);

  logic [16:0] lo_sum;
  logic [16:0] hi_sum0;
  logic [16:0] hi_sum1;
  logic [16:0] hi_sel;

  assign lo_sum  = {1'b0, din1[15:0]} + {1'b0, din2[15:0]} + {16'd0, carry_in};
  assign hi_sum0 = {1'b0, din1[31:16]} + {1'b0, din2[31:16]};
  assign hi_sum1 = {1'b0, din1[31:16]} + {1'b0, din2[31:16]} + 17'd1;
  assign hi_sel  = lo_sum[16] ? hi_sum1 : hi_sum0;

  assign dout      = {hi_sel[15:0], lo_sum[15:0]};
  assign carry_out = hi_sel[16];
  assign overflow  = (din1[31] == din2[31]) && (dout[31] != din1[31]);

endmodule

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit: 32 shift-add / restoring-divide steps through one shared adder.
module mdu_seq
  import mdu_seq_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  mdu_seq_if.slave  bus
);

  mdu_state_e  state_q, state_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
  logic        neg_pq_q, neg_pq_d, neg_r_q, neg_r_d;
  logic        dz_q, dz_d, done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        is_div;
  logic        start_signed;
  logic [31:0] r_shift;
  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        adder_ovf_unused;
  logic [63:0] prod, prod_fix;
  logic [31:0] q_fix, r_fix;

  assign is_div       = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign start_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);

  // Divide subtracts the divisor from the left-shifted remainder; multiply adds |rs| to P_hi.
  assign r_shift = {acc_hi_q[30:0], acc_lo_q[31]};
  assign add_a   = is_div ? r_shift : acc_hi_q;
  assign add_b   = is_div ? ~b_q : a_q;
  assign add_cin = is_div;

  csa32 u_csa32 (
    .din1      (add_a),
    .din2      (add_b),
    .carry_in  (add_cin),
    .dout      (add_sum),
    .carry_out (add_cout),
    .overflow  (adder_ovf_unused)
  );

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_pq_q ? (~prod + 64'd1) : prod;
  assign q_fix    = neg_pq_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
  assign r_fix    = neg_r_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sgn_a_d  = sgn_a_q;
    sgn_b_d  = sgn_b_q;
    neg_pq_d = neg_pq_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.mthi) hi_d = bus.wdata;
        if (bus.mtlo) lo_d = bus.wdata;
        if (bus.start) begin
          op_d    = mdu_op_e'(bus.op);
          a_d     = bus.rs_data;
          b_d     = bus.rt_data;
          sgn_a_d = start_signed & bus.rs_data[31];
          sgn_b_d = start_signed & bus.rt_data[31];
          dz_d    = 1'b0;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_pq_d = sgn_a_q ^ sgn_b_q;
        neg_r_d  = sgn_a_q;
        cnt_d    = '0;
        acc_hi_d = '0;
        // Divide-by-zero keeps the raw dividend in a_q so FIX can return it in HI.
        if (is_div && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = S_FIX;
        end else begin
          a_d      = mag32(a_q, sgn_a_q);
          b_d      = mag32(b_q, sgn_b_q);
          acc_lo_d = is_div ? mag32(a_q, sgn_a_q) : mag32(b_q, sgn_b_q);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div) begin
          acc_hi_d = (acc_hi_q[31] | add_cout) ? add_sum : r_shift;
          acc_lo_d = {acc_lo_q[30:0], acc_hi_q[31] | add_cout};
        end else if (acc_lo_q[0]) begin
          acc_hi_d = {add_cout, add_sum[31:1]};
          acc_lo_d = {add_sum[0], acc_lo_q[31:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[31:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = DIV_ZERO_LO;
        end else if (is_div) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= MDU_MULT;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      neg_pq_q <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sgn_a_q  <= sgn_a_d;
      sgn_b_q  <= sgn_b_d;
      neg_pq_q <= neg_pq_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = done_q & dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed-vector bench for mdu_seq with hand-computed HI/LO, latency and flag expectations.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_seq_if bus ();

  mdu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the sampling edge E0.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input logic exp_dz);
    int lat;
    launch(op, a, b);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd1);
    wait_done(lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check_eq({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    check_eq({tag, "_dz"}, 64'(bus.div_zero), 64'(exp_dz));
    check_eq({tag, "_idle"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] prev_hi;

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.mthi    = 1'b0;
    bus.mtlo    = 1'b0;
    bus.wdata   = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hi",   64'(bus.hi),   64'd0);
    check_eq("rst_lo",   64'(bus.lo),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 1'b0);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("div_negb",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("divu_small",2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        34, 1'b0);
    run_op("divu_big",  2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 34, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 1'b0);
    run_op("div_zero",  2'b10, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 2,  1'b1);
    run_op("divu_zero", 2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 2,  1'b1);

    // Second start and mthi while busy must both be dropped.
    prev_hi = bus.hi;
    launch(2'b01, 32'h0001_0000, 32'h0001_0000);
    repeat (10) @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = 2'b11;
    bus.rs_data = 32'd9;
    bus.rt_data = 32'd3;
    bus.mthi    = 1'b1;
    bus.wdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.mthi    = 1'b0;
    check_eq("busy_hi_stable", 64'(bus.hi), 64'(prev_hi));
    wait_done(lat);
    check_eq("busy_lat", 64'(lat + 11), 64'd34);
    check_eq("busy_hi", 64'(bus.hi), 64'h1);
    check_eq("busy_lo", 64'(bus.lo), 64'h0);
    @(negedge clk);
    check_eq("busy_after", 64'(bus.busy), 64'd0);

    bus.mtlo  = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.mtlo  = 1'b0;
    check_eq("mtlo_lo", 64'(bus.lo), 64'hA5A5_A5A5);
    check_eq("mtlo_hi", 64'(bus.hi), 64'h1);

    launch(2'b00, 32'd3, 32'd5);
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", 64'(bus.busy), 64'd0);
    check_eq("mrst_done", 64'(bus.done), 64'd0);
    check_eq("mrst_hi",   64'(bus.hi),   64'd0);
    check_eq("mrst_lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mrst_stay", 64'(bus.busy), 64'd0);
    run_op("post_rst", 2'b00, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 34, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
